// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing master for the 640x480@60 display path. It divides the board
//   clock down to a pixel-enable strobe, walks the horizontal/vertical raster
//   counters, and produces the sync, active-area and frame-start signals for
//   the pixel painter, the VGA connector and the per-frame game logic.
//
// Optional feature (compile-time macro):
//   VGA_FRAME_COUNTER_EN  defined   -> frame_count counts frame_start pulses
//                                      (16-bit, wraps 65535 -> 0)
//                         undefined -> frame_count tied to 0, no counter logic
//
// Ports:
//   clk          in   1   board clock (100 MHz)
//   reset_n      in   1   asynchronous active-low reset
//   pix_en       out  1   one-clk strobe every CLK_DIV clks
//   hCount       out  10  horizontal pixel counter, 0..H_TOTAL-1
//   vCount       out  10  vertical line counter, 0..V_TOTAL-1
//   hSync        out  1   horizontal sync, active low
//   vSync        out  1   vertical sync, active low
//   bright       out  1   high inside the visible area
//   frame_start  out  1   one-clk pulse when the raster wraps to (0,0)
//   frame_count  out  16  frames elapsed (0 when the counter is not built)
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_TOTAL = 800,
  parameter int H_SYNC  = 96,
  parameter int H_START = 144,
  parameter int H_END   = 784,
  parameter int V_TOTAL = 525,
  parameter int V_SYNC  = 2,
  parameter int V_START = 35,
  parameter int V_END   = 515
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        pix_en,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        hSync,
  output logic        vSync,
  output logic        bright,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]      H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]      V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]      H_SYNC_W = 10'(H_SYNC);
  localparam logic [9:0]      V_SYNC_W = 10'(V_SYNC);
  localparam logic [9:0]      H_BEG_W  = 10'(H_START);
  localparam logic [9:0]      H_END_W  = 10'(H_END);
  localparam logic [9:0]      V_BEG_W  = 10'(V_START);
  localparam logic [9:0]      V_END_W  = 10'(V_END);

  logic [DIV_W-1:0] div;
  logic             tick;    // last clk of a pixel period: everything advances here
  logic             wrap;    // raster is about to return to (0,0)
  logic [9:0]       h_next;
  logic [9:0]       v_next;

  // Next raster position; evaluated ahead of the edge so the decoded outputs
  // can be registered from it and land together with the counters.
  always_comb begin
    tick   = (div == DIV_LAST);
    wrap   = tick && (hCount == H_LAST) && (vCount == V_LAST);
    h_next = hCount;
    v_next = vCount;
    if (tick) begin
      if (hCount == H_LAST) begin
        h_next = 10'd0;
        if (vCount == V_LAST) begin
          v_next = 10'd0;
        end else begin
          v_next = vCount + 10'd1;
        end
      end else begin
        h_next = hCount + 10'd1;
        v_next = vCount;
      end
    end else begin
      h_next = hCount;
      v_next = vCount;
    end
  end

  // Clock divider and registered pixel-enable strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div    <= '0;
      pix_en <= 1'b0;
    end else begin
      if (tick) begin
        div <= '0;
      end else begin
        div <= div + DIV_W'(1);
      end
      pix_en <= tick;
    end
  end

  // Raster counters with sync/active decode taken from the next position,
  // so the decoded outputs never lag the counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hCount      <= 10'd0;
      vCount      <= 10'd0;
      hSync       <= 1'b0;
      vSync       <= 1'b0;
      bright      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (tick) begin
        hCount <= h_next;
        vCount <= v_next;
        hSync  <= (h_next >= H_SYNC_W);
        vSync  <= (v_next >= V_SYNC_W);
        bright <= (h_next >= H_BEG_W) && (h_next < H_END_W) &&
                  (v_next >= V_BEG_W) && (v_next < V_END_W);
      end else begin
        hCount <= hCount;
        vCount <= vCount;
        hSync  <= hSync;
        vSync  <= vSync;
        bright <= bright;
      end
      frame_start <= wrap;
    end
  end

`ifdef VGA_FRAME_COUNTER_EN
  logic [15:0] frames;

  // Frame counter steps on the same edge that raises frame_start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frames <= 16'd0;
    end else if (wrap) begin
      frames <= frames + 16'd1;
    end else begin
      frames <= frames;
    end
  end

  assign frame_count = frames;
`else
  assign frame_count = 16'd0;
`endif

endmodule
